// File: rtl/hangman_uart_pkg.sv
// Shared types and constants for the Hangman UART transmit path.
// Arbiter state encoding, byte width and default ack timeout.
package hangman_uart_pkg;

   localparam int BYTE_W          = 8;
   localparam int ACK_TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      LAUNCH    = 3'b001,
      WAIT_ACK  = 3'b010,
      WAIT_DONE = 3'b100
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant plus the
// last_grant flop that decides ties in favour of the other side.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       nRst,
   input  logic [1:0] valid_i,
   input  logic       enable_i,
   output logic [1:0] grant_onehot_o
);

   logic       last_grant_q;
   logic       last_grant_d;
   logic [1:0] grant_d;

   // Pick a requester; on a tie favour the one not granted last.
   always_comb begin
      grant_d      = 2'b00;
      last_grant_d = last_grant_q;
      if (enable_i) begin
         unique case (valid_i)
            2'b01:   grant_d = 2'b01;
            2'b10:   grant_d = 2'b10;
            2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
            default: grant_d = 2'b00;
         endcase
      end
      if (grant_d != 2'b00) begin
         last_grant_d = grant_d[1];
      end
   end

   // Remember the winner; reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign grant_onehot_o = grant_d;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between two byte requesters with round-robin
// arbitration, a launch/ack/done handshake and an ack watchdog.
module uart_tx_arbiter
   import hangman_uart_pkg::*;
#(
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              req0_valid,
   input  logic [BYTE_W-1:0] req0_byte,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [BYTE_W-1:0] req1_byte,
   output logic              req1_ready,
   input  logic              tx_ready,
   output logic              tx_ctrl,
   output logic [BYTE_W-1:0] tx_byte,
   output logic              busy,
   output logic              grant_id,
   output logic              done,
   output logic              timeout_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   arb_state_t        state_q;
   logic [BYTE_W-1:0] hold_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rdy0_q;
   logic              rdy1_q;
   logic              ctrl_q;
   logic              busy_q;
   logic              gid_q;
   logic              done_q;
   logic              to_q;

   logic [1:0]        grant;
   logic              arb_en;

   assign arb_en = (state_q == IDLE) && tx_ready;

   rr_arbiter2 u_arb (
      .clk            (clk),
      .nRst           (nRst),
      .valid_i        ({req1_valid, req0_valid}),
      .enable_i       (arb_en),
      .grant_onehot_o (grant)
   );

   // Transfer sequencer: accept, launch, wait for ack, wait for frame end.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         ctrl_q  <= 1'b0;
         busy_q  <= 1'b0;
         gid_q   <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         rdy0_q <= 1'b0;
         rdy1_q <= 1'b0;
         ctrl_q <= 1'b0;
         done_q <= 1'b0;
         to_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant[0]) begin
                  rdy0_q  <= 1'b1;
                  hold_q  <= req0_byte;
                  gid_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= LAUNCH;
               end else if (grant[1]) begin
                  rdy1_q  <= 1'b1;
                  hold_q  <= req1_byte;
                  gid_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               ctrl_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!tx_ready) begin
                  cnt_q   <= '0;
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  to_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            WAIT_DONE: begin
               if (tx_ready) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready  = rdy0_q;
   assign req1_ready  = rdy1_q;
   assign tx_ctrl     = ctrl_q;
   assign tx_byte     = hold_q;
   assign busy        = busy_q;
   assign grant_id    = gid_q;
   assign done        = done_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
// Expected launches are queued at stimulus time and popped on tx_ctrl.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_byte = 8'h00;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_byte = 8'h00;
   logic       req1_ready;
   logic       tx_ready;
   logic       tx_ctrl;
   logic [7:0] tx_byte;
   logic       busy;
   logic       grant_id;
   logic       done;
   logic       timeout_err;

   logic tx_hold_low = 1'b0;
   logic stall = 1'b0;
   int   busy_cnt = 0;
   int   cyc = 0;

   typedef struct {
      logic [7:0] b;
      logic       g;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int n_r0 = 0, n_r1 = 0, n_ctrl = 0, n_done = 0, n_to = 0;
   int ctrl_cyc = 0, to_cyc = 0;
   int r0, r1, c0, d0, t0;

   uart_tx_arbiter #(.ACK_TIMEOUT(16), .CNT_W(8)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .req0_valid  (req0_valid),
      .req0_byte   (req0_byte),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_byte   (req1_byte),
      .req1_ready  (req1_ready),
      .tx_ready    (tx_ready),
      .tx_ctrl     (tx_ctrl),
      .tx_byte     (tx_byte),
      .busy        (busy),
      .grant_id    (grant_id),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: goes busy the cycle after a launch, for 10 cycles
   assign tx_ready = !tx_hold_low && (busy_cnt == 0);

   always @(posedge clk) begin
      if (tx_ctrl && !stall) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: count pulses and score every launch
   always @(negedge clk) begin
      if (req0_ready) n_r0++;
      if (req1_ready) n_r1++;
      if (done) n_done++;
      if (timeout_err) begin
         n_to++;
         to_cyc = cyc;
      end
      if (tx_ctrl) begin
         n_ctrl++;
         ctrl_cyc = cyc;
         check("sb_has_entry", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("launch_byte", tx_byte, e.b);
            check("launch_gid", grant_id, e.g);
         end
      end
   end

   task automatic snap();
      r0 = n_r0; r1 = n_r1; c0 = n_ctrl; d0 = n_done; t0 = n_to;
   endtask

   task automatic wait_for(input int sel, input int max,
                           input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < max && !hit; i++) begin
         @(negedge clk);
         case (sel)
            0: hit = req0_ready;
            1: hit = req1_ready;
            2: hit = done;
            3: hit = timeout_err;
            default: hit = tx_ctrl;
         endcase
      end
      check(tag, 32'(hit), 1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      nRst = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ctrl", tx_ctrl, 0);
      check("rst_byte", tx_byte, 8'h00);
      check("rst_gid", grant_id, 0);
      check("rst_ready", {req1_ready, req0_ready}, 0);
      check("rst_pulses", {done, timeout_err}, 0);
      nRst = 1'b1;

      // single request on req0
      @(negedge clk);
      snap();
      sb.push_back('{b: 8'h41, g: 1'b0});
      req0_byte = 8'h41;
      req0_valid = 1'b1;
      wait_for(0, 10, "single_rdy_seen");
      req0_valid = 1'b0;
      wait_for(2, 40, "single_done_seen");
      @(negedge clk); #1;
      check("single_rdy0", n_r0 - r0, 1);
      check("single_ctrl", n_ctrl - c0, 1);
      check("single_done", n_done - d0, 1);
      check("single_gid", grant_id, 0);
      check("single_idle", busy, 0);

      // tie after reset: 0, 1, 0
      pulse_reset();
      snap();
      sb.push_back('{b: 8'h41, g: 1'b0});
      sb.push_back('{b: 8'h5A, g: 1'b1});
      sb.push_back('{b: 8'h41, g: 1'b0});
      req0_byte = 8'h41;
      req1_byte = 8'h5A;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) wait_for(2, 60, "tie_done_seen");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) @(negedge clk); #1;
      check("tie_rdy0", n_r0 - r0, 2);
      check("tie_rdy1", n_r1 - r1, 1);
      check("tie_ctrl", n_ctrl - c0, 3);
      check("tie_done", n_done - d0, 3);
      check("tie_sb_empty", sb.size(), 0);

      // stalled transmitter: watchdog abort
      snap();
      stall = 1'b1;
      sb.push_back('{b: 8'h77, g: 1'b1});
      req1_byte = 8'h77;
      req1_valid = 1'b1;
      wait_for(1, 10, "stall_rdy_seen");
      req1_valid = 1'b0;
      wait_for(3, 40, "stall_to_seen");
      @(negedge clk); #1;
      check("stall_to_latency", to_cyc - ctrl_cyc, 16);
      repeat (20) @(negedge clk); #1;
      check("stall_ctrl_once", n_ctrl - c0, 1);
      check("stall_to_once", n_to - t0, 1);
      check("stall_no_done", n_done - d0, 0);
      check("stall_idle", busy, 0);
      stall = 1'b0;

      // busy gating: tx_ready low in IDLE
      snap();
      tx_hold_low = 1'b1;
      sb.push_back('{b: 8'h3C, g: 1'b1});
      req1_byte = 8'h3C;
      req1_valid = 1'b1;
      repeat (6) @(negedge clk); #1;
      check("gate_no_rdy", n_r1 - r1, 0);
      check("gate_no_ctrl", n_ctrl - c0, 0);
      check("gate_idle", busy, 0);
      tx_hold_low = 1'b0;
      @(negedge clk);
      check("gate_accept", req1_ready, 1);
      req1_valid = 1'b0;
      wait_for(2, 40, "gate_done_seen");
      @(negedge clk); #1;
      check("gate_ctrl", n_ctrl - c0, 1);

      // withdrawal while busy
      snap();
      sb.push_back('{b: 8'h22, g: 1'b1});
      req1_byte = 8'h22;
      req1_valid = 1'b1;
      wait_for(1, 10, "wd_rdy_seen");
      req1_valid = 1'b0;
      wait_for(4, 10, "wd_ctrl_seen");
      @(negedge clk);
      req0_byte = 8'h99;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      wait_for(2, 40, "wd_done_seen");
      repeat (5) @(negedge clk); #1;
      check("wd_no_rdy0", n_r0 - r0, 0);
      check("wd_ctrl", n_ctrl - c0, 1);
      check("wd_done", n_done - d0, 1);
      check("wd_sb_empty", sb.size(), 0);

      // reset mid-WAIT_DONE
      snap();
      sb.push_back('{b: 8'h55, g: 1'b0});
      req0_byte = 8'h55;
      req0_valid = 1'b1;
      wait_for(0, 10, "mid_rdy_seen");
      req0_valid = 1'b0;
      wait_for(4, 10, "mid_ctrl_seen");
      repeat (3) @(negedge clk);
      check("mid_busy", busy, 1);
      nRst = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ctrl", tx_ctrl, 0);
      check("mid_rst_byte", tx_byte, 8'h00);
      check("mid_rst_done", done, 0);
      repeat (15) @(negedge clk); #1;
      check("mid_no_done", n_done - d0, 0);
      check("mid_ctrl", n_ctrl - c0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
